// File: rtl/pmem_line_adapter.sv
// Responder for the cache's line-wide physical-memory port.
// Each 128-bit line request is served as eight back-to-back 16-bit word transactions.
module pmem_line_adapter #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic [ADDR_WIDTH-1:0] wmem_address,
  output logic                  wmem_read,
  output logic                  wmem_write,
  output logic [WORD_WIDTH-1:0] wmem_wdata,
  input  logic [WORD_WIDTH-1:0] wmem_rdata,
  input  logic                  wmem_resp
);

  localparam int unsigned BEATS      = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_WIDTH / 8);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] rdata_d;
  logic                  resp_d;
  logic                  wread_d;
  logic                  wwrite_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [WORD_WIDTH-1:0] wwdata_d;

  // State and all outputs register together; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      base_q       <= '0;
      line_q       <= '0;
      pmem_rdata   <= '0;
      pmem_resp    <= 1'b0;
      wmem_read    <= 1'b0;
      wmem_write   <= 1'b0;
      wmem_address <= '0;
      wmem_wdata   <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      line_q       <= line_d;
      pmem_rdata   <= rdata_d;
      pmem_resp    <= resp_d;
      wmem_read    <= wread_d;
      wmem_write   <= wwrite_d;
      wmem_address <= waddr_d;
      wmem_wdata   <= wwdata_d;
    end
  end

  // Next state, then the word-port outputs derived from the state being entered.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    base_d   = base_q;
    line_d   = line_q;
    rdata_d  = pmem_rdata;
    resp_d   = 1'b0;
    wread_d  = 1'b0;
    wwrite_d = 1'b0;
    waddr_d  = '0;
    wwdata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        beat_d = '0;
        // Writeback takes priority so a dirty victim leaves before the fill.
        if (pmem_write) begin
          base_d  = pmem_address & LINE_MASK;
          line_d  = pmem_wdata;
          state_d = S_WRITE;
        end else if (pmem_read) begin
          base_d  = pmem_address & LINE_MASK;
          state_d = S_READ;
        end
      end
      S_READ, S_WRITE: begin
        if (wmem_resp) begin
          if (state_q == S_READ) begin
            rdata_d[beat_q*WORD_WIDTH +: WORD_WIDTH] = wmem_rdata;
          end
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DONE: begin
        beat_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    resp_d   = (state_d == S_DONE);
    wread_d  = (state_d == S_READ);
    wwrite_d = (state_d == S_WRITE);
    // Base is line aligned, so the beat offset never carries past the line.
    if (wread_d || wwrite_d) begin
      waddr_d = base_d | (ADDR_WIDTH'(beat_d) << WORD_SHIFT);
    end
    if (wwrite_d) begin
      wwdata_d = line_d[beat_d*WORD_WIDTH +: WORD_WIDTH];
    end
  end

endmodule

// File: tb/tb_pmem_line_adapter.sv
// Directed bench for pmem_line_adapter: a word-memory responder with a transaction
// scoreboard of expected beats, plus hand-computed latency and line values.
module tb_pmem_line_adapter;

  typedef struct {
    logic         wr;
    logic [15:0]  addr;
    logic [15:0]  data;
    logic         last;
    logic [127:0] line;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  wmem_address;
  logic         wmem_read;
  logic         wmem_write;
  logic [15:0]  wmem_wdata;
  logic [15:0]  wmem_rdata;
  logic         wmem_resp;

  int           n_chk;
  int           n_fail;
  int           waits;
  int           wait_cnt;
  logic         idle_pulse;
  logic         resp_due;
  logic         rd_due;
  logic [127:0] due_line;
  beat_t        exp_q[$];
  logic [15:0]  mem [logic [15:0]];

  pmem_line_adapter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .wmem_address (wmem_address),
    .wmem_read    (wmem_read),
    .wmem_write   (wmem_write),
    .wmem_wdata   (wmem_wdata),
    .wmem_rdata   (wmem_rdata),
    .wmem_resp    (wmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push_line(input logic wr, input logic [15:0] base,
                           input logic [127:0] wdata, input logic [127:0] line);
    beat_t e;
    for (int i = 0; i < 8; i++) begin
      e.wr   = wr;
      e.addr = base + 16'(2 * i);
      e.data = wdata[16*i +: 16];
      e.last = (i == 7);
      e.line = line;
      exp_q.push_back(e);
    end
  endtask

  // Change request fields just after acceptance; the adapter must ignore them.
  task automatic scramble();
    @(posedge clk);
    #1;
    pmem_address = 16'h5550;
    pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_resp(input string nm, input int exp_cyc);
    int got;
    got = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (pmem_resp) begin
        got = n;
        break;
      end
    end
    chk(nm, 128'(got), 128'(exp_cyc));
  endtask

  // Word-memory responder and per-cycle scoreboard check.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      exp_q.delete();
      resp_due  = 1'b0;
      rd_due    = 1'b0;
      wait_cnt  = 0;
      wmem_resp = 1'b0;
    end else begin
      chk("pmem_resp", 128'(pmem_resp), 128'(resp_due));
      if (resp_due && rd_due) chk("pmem_rdata at resp", pmem_rdata, due_line);
      resp_due  = 1'b0;
      wmem_resp = 1'b0;
      chk("read/write exclusive", 128'(wmem_read & wmem_write), 128'(0));
      if (exp_q.size() == 0) begin
        chk("idle word port", 128'({wmem_read, wmem_write}), 128'(0));
        wmem_resp  = idle_pulse;
        wmem_rdata = 16'hBEEF;
      end else if (wmem_read || wmem_write) begin
        e = exp_q[0];
        chk("wmem_read", 128'(wmem_read), 128'(!e.wr));
        chk("wmem_write", 128'(wmem_write), 128'(e.wr));
        chk("wmem_address", 128'(wmem_address), 128'(e.addr));
        if (e.wr) chk("wmem_wdata", 128'(wmem_wdata), 128'(e.data));
        if (wait_cnt == waits) begin
          wmem_resp = 1'b1;
          wait_cnt  = 0;
          if (e.wr) mem[e.addr] = wmem_wdata;
          else wmem_rdata = mem.exists(e.addr) ? mem[e.addr] : 16'h0000;
          void'(exp_q.pop_front());
          if (e.last) begin
            resp_due = 1'b1;
            rd_due   = !e.wr;
            due_line = e.line;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 50000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    n_chk = 0; n_fail = 0; waits = 0; wait_cnt = 0;
    idle_pulse = 1'b0; resp_due = 1'b0; rd_due = 1'b0; due_line = '0;
    rst_n = 1'b0; pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_wdata = '0; wmem_rdata = '0; wmem_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem[16'h1230 + 16'(2*i)] = 16'hA000 + 16'(i);
      mem[16'hFFF0 + 16'(2*i)] = 16'h5A00 + 16'(i);
    end

    #1;
    chk("reset pmem_resp", 128'(pmem_resp), 128'(0));
    chk("reset pmem_rdata", pmem_rdata, 128'(0));
    chk("reset wmem_req", 128'({wmem_read, wmem_write}), 128'(0));
    chk("reset wmem_address", 128'(wmem_address), 128'(0));
    chk("reset wmem_wdata", 128'(wmem_wdata), 128'(0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Zero-wait read of 0x1234's line.
    @(negedge clk);
    waits = 0;
    push_line(1'b0, 16'h1230, '0, 128'hA007_A006_A005_A004_A003_A002_A001_A000);
    pmem_address = 16'h1234; pmem_read = 1'b1;
    scramble();
    wait_resp("read0 latency", 9);
    pmem_read = 1'b0;
    chk("read0 line", pmem_rdata, 128'hA007_A006_A005_A004_A003_A002_A001_A000);

    // Three wait cycles per beat, request dropped mid-burst.
    @(negedge clk);
    waits = 3;
    push_line(1'b0, 16'h1230, '0, 128'hA007_A006_A005_A004_A003_A002_A001_A000);
    pmem_address = 16'h1230; pmem_read = 1'b1;
    scramble();
    pmem_read = 1'b0;
    wait_resp("read3 latency", 33);
    chk("read3 line", pmem_rdata, 128'hA007_A006_A005_A004_A003_A002_A001_A000);

    // Line write to 0x8000.
    @(negedge clk);
    waits = 0;
    push_line(1'b1, 16'h8000, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, '0);
    pmem_address = 16'h8000; pmem_write = 1'b1;
    pmem_wdata = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    scramble();
    wait_resp("write latency", 9);
    pmem_write = 1'b0;
    chk("mem 0x8000", 128'(mem[16'h8000]), 128'h0100);
    chk("mem 0x8006", 128'(mem[16'h8006]), 128'h0706);
    chk("mem 0x800E", 128'(mem[16'h800E]), 128'h0F0E);

    // Read and write together: write first, then the held read.
    @(negedge clk);
    push_line(1'b1, 16'h4010, 128'h8888_7777_6666_5555_4444_3333_2222_1111, '0);
    push_line(1'b0, 16'h4010, '0, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
    pmem_address = 16'h4010; pmem_write = 1'b1; pmem_read = 1'b1;
    pmem_wdata = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    wait_resp("both: write resp", 9);
    pmem_write = 1'b0;
    wait_resp("both: read resp", 10);
    pmem_read = 1'b0;
    chk("both: read line", pmem_rdata, 128'h8888_7777_6666_5555_4444_3333_2222_1111);

    // Reset during beat 4 of a read.
    @(negedge clk);
    push_line(1'b0, 16'h1230, '0, 128'hA007_A006_A005_A004_A003_A002_A001_A000);
    pmem_address = 16'h1234; pmem_read = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (wmem_read && wmem_address == 16'h1238) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach beat 4", 128'(found), 128'(1));
    #2 rst_n = 1'b0; pmem_read = 1'b0;
    #1;
    chk("midrst wmem_req", 128'({wmem_read, wmem_write}), 128'(0));
    chk("midrst wmem_address", 128'(wmem_address), 128'(0));
    chk("midrst pmem_rdata", pmem_rdata, 128'(0));
    chk("midrst pmem_resp", 128'(pmem_resp), 128'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push_line(1'b0, 16'h1230, '0, 128'hA007_A006_A005_A004_A003_A002_A001_A000);
    pmem_address = 16'h1234; pmem_read = 1'b1;
    scramble();
    wait_resp("post-reset latency", 9);
    pmem_read = 1'b0;
    chk("post-reset line", pmem_rdata, 128'hA007_A006_A005_A004_A003_A002_A001_A000);

    // Top-of-memory line, then stray word responses while idle.
    @(negedge clk);
    push_line(1'b0, 16'hFFF0, '0, 128'h5A07_5A06_5A05_5A04_5A03_5A02_5A01_5A00);
    pmem_address = 16'hFFFC; pmem_read = 1'b1;
    scramble();
    wait_resp("fff0 latency", 9);
    pmem_read = 1'b0;
    chk("fff0 line", pmem_rdata, 128'h5A07_5A06_5A05_5A04_5A03_5A02_5A01_5A00);
    @(negedge clk);
    chk("resp one cycle", 128'(pmem_resp), 128'(0));
    idle_pulse = 1'b1;
    repeat (6) @(negedge clk);
    idle_pulse = 1'b0;
    chk("stray resp: no word req", 128'({wmem_read, wmem_write}), 128'(0));
    chk("stray resp: no pmem_resp", 128'(pmem_resp), 128'(0));
    chk("stray resp: line kept", pmem_rdata, 128'h5A07_5A06_5A05_5A04_5A03_5A02_5A01_5A00);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
